// File: rtl/button_arbiter.sv
// Debounced single-button arbiter: per-button sync+debounce, press/auto-repeat strobes,
// multi-button lockout. Define AUTO_REPEAT_EN to enable the auto-repeat counter.

module button_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level
);
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // level flips only after sync[1] has disagreed for DB_CYCLES consecutive edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module button_arbiter #(
  parameter int               N_BTN      = 5,
  parameter int               DB_CYCLES  = 4,
  parameter int               RPT_DELAY  = 32,
  parameter int               RPT_PERIOD = 8,
  parameter logic [N_BTN-1:0] GRP_A_MASK = 5'b00011,
  parameter logic [N_BTN-1:0] GRP_B_MASK = 5'b01100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] pulse,
  output logic [1:0]       select,
  output logic             lockout
);
  localparam int CW = $clog2(N_BTN + 1);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT, S_LOCK} state_t;

  if (N_BTN < 2 || N_BTN > 16 || DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
    $error("button_arbiter: parameter out of range");
  end

  logic [N_BTN-1:0] deb;
  logic [N_BTN-1:0] cap;
  logic [CW-1:0]    cnt;
  state_t           state;

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .btn    (btn[i]),
      .level  (deb[i])
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_BTN; i++) cnt = cnt + CW'(deb[i]);
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX);

  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_lim;

  assign rpt_lim = (state == S_HELD) ? RW'(RPT_DELAY - 1) : RW'(RPT_PERIOD - 1);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cap     <= '0;
      held    <= '0;
      pulse   <= '0;
      select  <= '0;
      lockout <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt <= '0;
`endif
    end else begin
      pulse <= '0;
      case (state)
        S_IDLE: begin
          if (cnt == CW'(1)) begin
            // deb is one-hot here, so it doubles as the captured index
            state  <= S_HELD;
            cap    <= deb;
            held   <= deb;
            pulse  <= deb;
            select <= {|(deb & GRP_A_MASK), |(deb & GRP_B_MASK)};
`ifdef AUTO_REPEAT_EN
            rpt_cnt <= '0;
`endif
          end else if (cnt > CW'(1)) begin
            state   <= S_LOCK;
            lockout <= 1'b1;
          end
        end
        S_HELD, S_REPEAT: begin
          if (cnt == '0) begin
            state  <= S_IDLE;
            held   <= '0;
            select <= '0;
          end else if (|(deb & ~cap)) begin
            state   <= S_LOCK;
            held    <= '0;
            select  <= '0;
            lockout <= 1'b1;
          end
`ifdef AUTO_REPEAT_EN
          else if (rpt_cnt == rpt_lim) begin
            state   <= S_REPEAT;
            pulse   <= cap;
            rpt_cnt <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end
        S_LOCK: begin
          if (cnt == '0) begin
            state   <= S_IDLE;
            lockout <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
